imem_prefetch_buffer: RTL and testbench

IMEM_PREFETCH_BUFFER -- requirements
Module: imem_prefetch_buffer

---
 rtl/imem_prefetch_buffer_if.sv | 34 +++
 rtl/imem_prefetch_buffer.sv | 105 ++++++++++
 tb/tb_imem_prefetch_buffer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_prefetch_buffer_if.sv
// Fetch-side bundle of the instruction prefetch buffer: memory request/response,
// IF/ID delivery and EX redirect. master = prefetch buffer, slave = environment.
interface imem_prefetch_buffer_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DATA_W-1:0] fetch_instr;

  modport master (
    input  redirect, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output fetch_valid, fetch_pc, fetch_instr,
    input  fetch_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  fetch_valid, fetch_pc, fetch_instr,
    output fetch_ready
  );
endinterface

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch FIFO: keeps up to DEPTH words fetched or in flight ahead of
// IF/ID, and flushes buffered plus in-flight words on a redirect from EX.
module imem_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_prefetch_buffer_if.master   bus,
  output logic [$clog2(DEPTH):0]   dbg_occupancy
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_pc    [DEPTH];
  logic [DATA_W-1:0] fifo_instr [DEPTH];

  logic              req_fire;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    in_use;
  logic [CNT_W-1:0]  outstanding_nxt;
  logic [ADDR_W-1:0] redirect_target;

  // Occupied plus in-flight slots bound issue, so a response always finds room.
  assign in_use            = {1'b0, occupancy} + {1'b0, outstanding};
  assign bus.mem_req_valid = !rst && (in_use < (CNT_W+1)'(DEPTH));
  assign bus.mem_req_addr  = next_pc;

  assign req_fire        = bus.mem_req_valid && bus.mem_req_ready;
  assign rsp_drop        = bus.redirect || (state == DRAIN);
  assign push            = bus.mem_rsp_valid && !rsp_drop;
  assign pop             = bus.fetch_valid && bus.fetch_ready && !bus.redirect;
  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(bus.mem_rsp_valid);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.fetch_valid = (occupancy != '0);
  assign bus.fetch_pc    = bus.fetch_valid ? fifo_pc[rd_ptr]    : '0;
  assign bus.fetch_instr = bus.fetch_valid ? fifo_instr[rd_ptr] : '0;
  assign dbg_occupancy   = occupancy;

  // Control state; drop_cnt counts in-flight responses that belong to a flushed stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      next_pc     <= RESET_PC;
      rsp_pc      <= RESET_PC;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect) begin
        next_pc   <= redirect_target;
        rsp_pc    <= redirect_target;
        occupancy <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        drop_cnt  <= outstanding_nxt;
        state     <= (outstanding_nxt != '0) ? DRAIN : RUN;
      end else begin
        if (req_fire) next_pc <= next_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
        case (state)
          RUN: ;
          DRAIN: begin
            if (bus.mem_rsp_valid) begin
              drop_cnt <= drop_cnt - CNT_W'(1);
              if (drop_cnt == CNT_W'(1)) state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= bus.mem_rsp_data;
    end
  end
endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Bench for imem_prefetch_buffer: in-order memory model with settable latency,
// expected-PC scoreboard checked by an independent monitor, directed scenarios.
module tb_imem_prefetch_buffer;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_occupancy;

  imem_prefetch_buffer_if bus ();

  imem_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .dbg_occupancy (dbg_occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: accepted requests answered in order after lat cycles.
  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc      = 0;
  int    lat      = 1;
  int    fire_cnt = 0;

  always @(negedge clk) begin
    mreq_t e;
    cyc++;
    if (rst) begin
      mq.delete();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
    end
    #3;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      e.addr = bus.mem_req_addr;
      e.due  = cyc + lat;
      mq.push_back(e);
      fire_cnt++;
    end
  end

  // Scoreboard: PCs the pipeline is expected to receive, in order.
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    #3;
    if (!rst && !bus.redirect) begin
      if (bus.mem_rsp_valid)
        chk("rsp_when_full", 32'(dbg_occupancy == 3'(DEPTH)), 32'd0);
      if (bus.fetch_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc %h want none", bus.fetch_pc);
        end else begin
          chk("fetch_pc", bus.fetch_pc, exp_q[0]);
          chk("fetch_instr", bus.fetch_instr, word_of(exp_q[0]));
          if (bus.fetch_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("empty_pc", bus.fetch_pc, 32'd0);
        chk("empty_instr", bus.fetch_instr, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_expect(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    set_expect(pc & 32'hFFFF_FFFC);
    step();
    bus.redirect = 1'b0;
  endtask

  task automatic wait_fetch(input string name, input logic [31:0] exp_pc);
    int i;
    for (i = 0; i < 30; i++) begin
      if (bus.fetch_valid) break;
      step();
    end
    if (i == 30) begin
      total++;
      bad++;
      $display("FAIL %s: got no fetch_valid want pc %h", name, exp_pc);
    end else begin
      chk(name, bus.fetch_pc, exp_pc);
    end
  endtask

  initial begin
    int vcnt;
    int f0;
    int i;
    rst               = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_pc   = '0;
    bus.mem_req_ready = 1'b1;
    bus.fetch_ready   = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    repeat (3) step();

    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_pc", bus.fetch_pc, 32'd0);
    chk("rst_fetch_instr", bus.fetch_instr, 32'd0);
    chk("rst_occupancy", 32'(dbg_occupancy), 32'd0);

    // Streaming from RESET_PC with a 1-cycle memory
    set_expect(32'h0);
    bus.fetch_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("first_req_addr", bus.mem_req_addr, 32'd0);
    step();
    step();
    chk("first_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    chk("first_fetch_pc", bus.fetch_pc, 32'd0);
    vcnt = 0;
    repeat (12) begin
      step();
      vcnt += int'(bus.fetch_valid);
    end
    chk("stream_rate", 32'(vcnt), 32'd12);

    // Back-pressure
    bus.fetch_ready = 1'b0;
    repeat (10) step();
    chk("bp_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("bp_occupancy", 32'(dbg_occupancy), 32'd4);
    f0 = fire_cnt;
    bus.fetch_ready = 1'b1;
    step();
    bus.fetch_ready = 1'b0;
    repeat (8) step();
    chk("bp_one_request", 32'(fire_cnt - f0), 32'd1);
    chk("bp_refill_occ", 32'(dbg_occupancy), 32'd4);

    // Redirect with a 3-cycle memory and requests in flight
    lat = 3;
    bus.fetch_ready = 1'b1;
    repeat (12) step();
    do_redirect(32'h0000_0100);
    wait_fetch("redir_first_pc", 32'h0000_0100);

    // Redirect while still draining a previous redirect
    repeat (6) step();
    do_redirect(32'h0000_0300);
    step();
    do_redirect(32'h0000_0400);
    wait_fetch("drain_redir_pc", 32'h0000_0400);

    // Redirect coinciding with a response and an accepted request
    lat = 1;
    repeat (10) step();
    for (i = 0; i < 20; i++) begin
      if (bus.mem_rsp_valid && bus.mem_req_valid && bus.mem_req_ready) break;
      step();
    end
    if (i == 20) begin
      total++;
      bad++;
      $display("FAIL coincide_setup: got no rsp+req cycle want one");
    end
    do_redirect(32'h0000_0203);
    wait_fetch("coincide_pc", 32'h0000_0200);

    // Address wrap
    repeat (4) step();
    do_redirect(32'hFFFF_FFF8);
    wait_fetch("wrap_pc0", 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", bus.fetch_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2_valid", 32'(bus.fetch_valid), 32'd1);
    chk("wrap_pc2", bus.fetch_pc, 32'h0000_0000);

    // Reset mid-stream with three entries buffered
    bus.fetch_ready = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (dbg_occupancy == 3'd3) break;
      step();
    end
    chk("mid_occupancy", 32'(dbg_occupancy), 32'd3);
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("mid_rst_occ", 32'(dbg_occupancy), 32'd0);
    chk("mid_rst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("mid_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    set_expect(32'h0);
    bus.fetch_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("restart_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("restart_req_addr", bus.mem_req_addr, 32'd0);
    wait_fetch("restart_pc", 32'h0000_0000);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
